wm8731_adc_receiver: RTL and testbench

Capture side of the WM8731 audio interface, companion to wm8731_controller, which drives the DAC side.
- Samples the codec's ADCDAT serial stream in DSP mode A, framed by ADCLRC and clocked by the shared 1.024 MHz BCLK.
- Runs entirely in the 240 MHz clk domain; BCLK, ADCLRC and ADCDAT are oversampled.
- Delivers one stereo 16-bit sample pair per 32 kHz frame, with a one-cycle valid strobe, to downstream FM/audio processing.

---
 rtl/wm8731_pkg.sv | 15 +
 rtl/wm8731_adc_receiver_if.sv | 25 ++
 rtl/wm8731_adc_receiver_bit_sync.sv | 41 ++++
 rtl/wm8731_adc_receiver.sv | 114 +++++++++++
 tb/tb_wm8731_adc_receiver.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/wm8731_pkg.sv
// Types and constants shared by the WM8731 capture and playback paths.
package wm8731_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int FRAME_BITS  = 2 * SAMPLE_BITS;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } rx_state_t;

endpackage

// File: rtl/wm8731_adc_receiver_if.sv
// Codec-side serial pins plus the decoded stereo sample outputs of the ADC receiver.
interface wm8731_adc_receiver_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  bclk;
  logic                  adc_lr_ck;
  logic                  adc_dat;
  logic [DATA_WIDTH-1:0] adc_left;
  logic [DATA_WIDTH-1:0] adc_right;
  logic                  adc_valid;
  logic                  sync_err;

  // master: the codec side driving the serial pins and observing samples
  modport master (
    output bclk, adc_lr_ck, adc_dat,
    input  adc_left, adc_right, adc_valid, sync_err
  );

  modport slave (
    input  bclk, adc_lr_ck, adc_dat,
    output adc_left, adc_right, adc_valid, sync_err
  );

endinterface

// File: rtl/wm8731_adc_receiver_bit_sync.sv
// Oversampling synchroniser for BCLK/ADCLRC/ADCDAT with a registered BCLK rising-edge pulse.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bclk,
  input  logic adc_lr_ck,
  input  logic adc_dat,
  output logic rise,
  output logic lrc_s,
  output logic dat_s
);

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrc_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_prev;

  // lrc_s/dat_s take one extra flop so they line up with the registered rise pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
      rise      <= 1'b0;
      lrc_s     <= 1'b0;
      dat_s     <= 1'b0;
    end else begin
      bclk_sync <= (bclk_sync << 1) | SYNC_STAGES'(bclk);
      lrc_sync  <= (lrc_sync << 1)  | SYNC_STAGES'(adc_lr_ck);
      dat_sync  <= (dat_sync << 1)  | SYNC_STAGES'(adc_dat);
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
      rise      <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
      lrc_s     <= lrc_sync[SYNC_STAGES-1];
      dat_s     <= dat_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/wm8731_adc_receiver.sv
// WM8731 ADC capture in DSP mode A: deserialises ADCDAT into stereo samples, one strobe per frame.
module wm8731_adc_receiver
  import wm8731_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  wm8731_adc_receiver_if.slave bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                  rise;
  logic                  lrc_s;
  logic                  dat_s;
  rx_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] left_sr;
  logic [DATA_WIDTH-1:0] right_sr;
  logic [DATA_WIDTH-1:0] left_q;
  logic [DATA_WIDTH-1:0] right_q;
  logic                  valid_q;
  logic                  err_q;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bit_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk      (bus.bclk),
    .adc_lr_ck (bus.adc_lr_ck),
    .adc_dat   (bus.adc_dat),
    .rise      (rise),
    .lrc_s     (lrc_s),
    .dat_s     (dat_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      left_sr  <= '0;
      right_sr <= '0;
      left_q   <= '0;
      right_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (rise) begin
        case (state)
          IDLE: begin
            // the marker bit carries no data in DSP mode A
            if (lrc_s) begin
              state <= LEFT;
              cnt   <= '0;
            end
          end
          LEFT: begin
            if (lrc_s) begin
              err_q    <= 1'b1;
              cnt      <= '0;
              left_sr  <= '0;
              right_sr <= '0;
            end else begin
              left_sr <= {left_sr[DATA_WIDTH-2:0], dat_s};
              if (cnt == LAST_BIT) begin
                state <= RIGHT;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          RIGHT: begin
            if (lrc_s && (cnt != LAST_BIT)) begin
              err_q    <= 1'b1;
              state    <= LEFT;
              cnt      <= '0;
              left_sr  <= '0;
              right_sr <= '0;
            end else begin
              right_sr <= {right_sr[DATA_WIDTH-2:0], dat_s};
              if (cnt == LAST_BIT) begin
                // a marker on the right LSB starts the next frame back-to-back
                left_q  <= left_sr;
                right_q <= {right_sr[DATA_WIDTH-2:0], dat_s};
                valid_q <= 1'b1;
                state   <= lrc_s ? LEFT : IDLE;
                cnt     <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.adc_left  = left_q;
  assign bus.adc_right = right_q;
  assign bus.adc_valid = valid_q;
  assign bus.sync_err  = err_q;

endmodule

// File: tb/tb_wm8731_adc_receiver.sv
// Directed bench for wm8731_adc_receiver with a DSP-mode-A codec model.
`timescale 1ns/1ps
module tb_wm8731_adc_receiver;

  localparam int  DW        = 16;
  localparam int  SS        = 2;
  localparam real CLK_HALF  = 2.083;
  // bclk runs faster than the codec's 1.024 MHz to keep run time short; the receiver is rate-agnostic
  localparam real BCLK_HALF = 35.0;
  localparam int  NB2B      = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  wm8731_adc_receiver_if #(.DATA_WIDTH(DW)) bus ();

  wm8731_adc_receiver #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #(CLK_HALF) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          valid_cnt = 0;
  int          err_cnt   = 0;
  int          both_cnt  = 0;
  logic [15:0] v_left[$];
  logic [15:0] v_right[$];
  int          v_cyc[$];
  int          last_rise_cyc = 0;

  always @(negedge clk) begin
    if (bus.adc_valid) begin
      valid_cnt++;
      v_left.push_back(bus.adc_left);
      v_right.push_back(bus.adc_right);
      v_cyc.push_back(cyc);
    end
    if (bus.sync_err) err_cnt++;
    if (bus.adc_valid && bus.sync_err) both_cnt++;
  end

  task automatic clear_mon();
    valid_cnt = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    v_left.delete();
    v_right.delete();
    v_cyc.delete();
  endtask

  task automatic send_bit(input logic lrc, input logic dat);
    bus.bclk      = 1'b0;
    bus.adc_lr_ck = lrc;
    bus.adc_dat   = dat;
    #(BCLK_HALF);
    bus.bclk      = 1'b1;
    last_rise_cyc = cyc;
    #(BCLK_HALF);
  endtask

  task automatic send_word(input logic [15:0] data, input logic marker_on_lsb);
    for (int i = DW - 1; i >= 0; i--)
      send_bit(marker_on_lsb && (i == 0), data[i]);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic next_marker);
    send_word(l, 1'b0);
    send_word(r, next_marker);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 40; i++) send_bit((i % 8) == 0, 1'($urandom_range(0, 1)));
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL reset_valid_cnt: got %0d expected 0", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (bus.adc_left !== 16'h0000) begin errors++; $display("FAIL reset_left: got %h expected 0000", bus.adc_left); end
    checks++; if (bus.adc_right !== 16'h0000) begin errors++; $display("FAIL reset_right: got %h expected 0000", bus.adc_right); end
    checks++; if ({bus.adc_valid, bus.sync_err} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {bus.adc_valid, bus.sync_err}); end
    reset_n = 1'b1;
    idle_bits(5);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL post_reset_valid_cnt: got %0d expected 0", valid_cnt); end
    checks++; if ({bus.adc_left, bus.adc_right} !== 32'h0) begin errors++; $display("FAIL post_reset_outputs: got %h expected 00000000", {bus.adc_left, bus.adc_right}); end
  endtask

  task automatic test_single_frame();
    int rise_c;
    int lat;
    clear_mon();
    send_bit(1'b1, 1'b0);
    send_frame(16'h8001, 16'h7FFE, 1'b0);
    rise_c = last_rise_cyc;
    idle_bits(4);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL single_valid_cnt: got %0d expected 1", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL single_err_cnt: got %0d expected 0", err_cnt); end
    if (valid_cnt >= 1) begin
      lat = v_cyc[0] - rise_c;
      checks++; if (v_left[0] !== 16'h8001) begin errors++; $display("FAIL single_left: got %h expected 8001", v_left[0]); end
      checks++; if (v_right[0] !== 16'h7FFE) begin errors++; $display("FAIL single_right: got %h expected 7ffe", v_right[0]); end
      checks++; if (lat < SS + 1 || lat > SS + 3) begin errors++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, SS + 1, SS + 3); end
    end
    checks++; if (bus.adc_left !== 16'h8001) begin errors++; $display("FAIL single_hold_left: got %h expected 8001", bus.adc_left); end
  endtask

  task automatic test_early_marker();
    clear_mon();
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
    send_bit(1'b1, 1'b0);
    send_frame(16'h1234, 16'hABCD, 1'b0);
    idle_bits(4);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL early_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL early_valid_cnt: got %0d expected 1", valid_cnt); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL early_both: got %0d expected 0", both_cnt); end
    if (valid_cnt >= 1) begin
      checks++; if (v_left[0] !== 16'h1234) begin errors++; $display("FAIL early_left: got %h expected 1234", v_left[0]); end
      checks++; if (v_right[0] !== 16'hABCD) begin errors++; $display("FAIL early_right: got %h expected abcd", v_right[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] l_exp[NB2B];
    logic [15:0] r_exp[NB2B];
    real         sp_exp;
    real         d;
    sp_exp = 32.0 * 2.0 * BCLK_HALF / (2.0 * CLK_HALF);
    for (int f = 0; f < NB2B; f++) begin
      l_exp[f] = 16'($urandom);
      r_exp[f] = 16'($urandom);
    end
    clear_mon();
    send_bit(1'b1, 1'b0);
    for (int f = 0; f < NB2B; f++) send_frame(l_exp[f], r_exp[f], f != NB2B - 1);
    idle_bits(4);
    checks++; if (valid_cnt !== NB2B) begin errors++; $display("FAIL b2b_valid_cnt: got %0d expected %0d", valid_cnt, NB2B); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL b2b_err_cnt: got %0d expected 0", err_cnt); end
    for (int f = 0; f < NB2B && f < valid_cnt; f++) begin
      checks++; if (v_left[f] !== l_exp[f]) begin errors++; $display("FAIL b2b_left[%0d]: got %h expected %h", f, v_left[f], l_exp[f]); end
      checks++; if (v_right[f] !== r_exp[f]) begin errors++; $display("FAIL b2b_right[%0d]: got %h expected %h", f, v_right[f], r_exp[f]); end
      if (f > 0) begin
        d = real'(v_cyc[f] - v_cyc[f-1]) - sp_exp;
        checks++; if (d > 2.0 || d < -2.0) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected about %0.1f", f, v_cyc[f] - v_cyc[f-1], sp_exp); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] word;
    word = 32'h5555_3333;
    clear_mon();
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == 20) begin
        reset_n = 1'b0;
        #10;
        checks++; if ({bus.adc_left, bus.adc_right} !== 32'h0) begin errors++; $display("FAIL midreset_outputs: got %h expected 00000000", {bus.adc_left, bus.adc_right}); end
        #10;
        reset_n = 1'b1;
      end
      send_bit(1'b0, word[31 - i]);
    end
    idle_bits(4);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL midreset_lost_frame: got %0d expected 0", valid_cnt); end
    send_bit(1'b1, 1'b0);
    send_frame(16'h0F0F, 16'hF0F0, 1'b0);
    idle_bits(4);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL midreset_valid_cnt: got %0d expected 1", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL midreset_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (bus.adc_left !== 16'h0F0F) begin errors++; $display("FAIL midreset_left: got %h expected 0f0f", bus.adc_left); end
    checks++; if (bus.adc_right !== 16'hF0F0) begin errors++; $display("FAIL midreset_right: got %h expected f0f0", bus.adc_right); end
  endtask

  task automatic test_no_framing();
    clear_mon();
    for (int i = 0; i < 1000; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
    idle_bits(2);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL noframe_valid_cnt: got %0d expected 0", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL noframe_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (bus.adc_left !== 16'h0F0F) begin errors++; $display("FAIL noframe_left_hold: got %h expected 0f0f", bus.adc_left); end
    checks++; if (bus.adc_right !== 16'hF0F0) begin errors++; $display("FAIL noframe_right_hold: got %h expected f0f0", bus.adc_right); end
  endtask

  initial begin
    bus.bclk      = 1'b0;
    bus.adc_lr_ck = 1'b0;
    bus.adc_dat   = 1'b0;
    reset_n       = 1'b0;
    #20;
    test_reset();
    test_single_frame();
    test_early_marker();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_framing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
